// File: rtl/sysid_ctrl_pkg.sv
// Shared types and constants for the system-ID boot check controller.
// Pulled into the FSM and its bench-facing top through import sysid_ctrl_pkg::*.
package sysid_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CMP,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    FAIL_NONE    = 2'd0,
    FAIL_ID      = 2'd1,
    FAIL_TS      = 2'd2,
    FAIL_TIMEOUT = 2'd3
  } fail_code_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_read_timer.sv
// Stall counter for one Avalon read attempt; flags the stall cycle that
// brings the count up to TIMEOUT_CYC so the sequencer can abort and retry.
module sysid_read_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);

  localparam logic [7:0] LastCount = 8'(TIMEOUT_CYC - 1);

  logic [7:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else if (clear_i) begin
      count_q <= 8'd0;
    end else if (enable_i) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign timeout_o = enable_i && (count_q == LastCount);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Boot-time sysid check: reads ID and timestamp words, compares them with
// build-time values and publishes a held pass/fail verdict.
module sysid_check_ctrl
  import sysid_ctrl_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS = 32'h0000_0000,
  parameter bit          CHECK_TS    = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [31:0] id_q,
  output logic [31:0] ts_q
);

  state_e     state_q;
  fail_code_e failCode_q;
  logic       autoRun_q;
  logic       mRead_q;
  logic       mAddress_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [2:0] retry_q;
  logic [31:0] idWord_q;
  logic [31:0] tsWord_q;

  logic readActive;
  logic timerClear;
  logic timerEnable;
  logic timeout;

  assign readActive  = ((state_q == RD_ID) || (state_q == RD_TS)) && mRead_q;
  assign timerClear  = !readActive || !m_waitrequest;
  assign timerEnable = readActive && m_waitrequest;

  sysid_read_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (timerClear),
    .enable_i (timerEnable),
    .timeout_o(timeout)
  );

  // autoRun_q makes the first clock after reset behave like a start pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      autoRun_q  <= 1'b1;
      mRead_q    <= 1'b0;
      mAddress_q <= ADDR_ID;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      failCode_q <= FAIL_NONE;
      retry_q    <= 3'd0;
      idWord_q   <= 32'd0;
      tsWord_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start || autoRun_q) begin
            autoRun_q  <= 1'b0;
            state_q    <= RD_ID;
            mRead_q    <= 1'b1;
            mAddress_q <= ADDR_ID;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            failCode_q <= FAIL_NONE;
            retry_q    <= 3'd0;
          end
        end
        RD_ID, RD_TS: begin
          if (!mRead_q) begin
            mRead_q <= 1'b1;
          end else if (!m_waitrequest) begin
            retry_q <= 3'd0;
            if (state_q == RD_ID) begin
              idWord_q   <= m_readdata;
              state_q    <= RD_TS;
              mAddress_q <= ADDR_TS;
            end else begin
              tsWord_q <= m_readdata;
              state_q  <= CMP;
              mRead_q  <= 1'b0;
            end
          end else if (timeout) begin
            // Abort this attempt; the one-cycle gap precedes the reissue.
            mRead_q <= 1'b0;
            if (retry_q == 3'(MAX_RETRY)) begin
              failCode_q <= FAIL_TIMEOUT;
              pass_q     <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end else begin
              retry_q <= retry_q + 3'd1;
            end
          end
        end
        CMP: begin
          if (idWord_q != EXPECTED_ID) begin
            failCode_q <= FAIL_ID;
            pass_q     <= 1'b0;
          end else if (CHECK_TS && (tsWord_q != EXPECTED_TS)) begin
            failCode_q <= FAIL_TS;
            pass_q     <= 1'b0;
          end else begin
            failCode_q <= FAIL_NONE;
            pass_q     <= 1'b1;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_read    = mRead_q;
  assign m_address = mAddress_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = failCode_q;
  assign id_q      = idWord_q;
  assign ts_q      = tsWord_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: a cycle-timeline model built from the protocol
// timing rules drives a per-cycle compare, plus literal spot checks.
module tb_sysid_check_ctrl;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h5AA5_0003;
  localparam int TO = 4;
  localparam int MR = 1;

  typedef struct {
    logic        rd;
    logic        addr;
    logic        busy;
    logic        done;
    logic        wr;
    logic [1:0]  codeA;
    logic [1:0]  codeB;
    logic [31:0] idq;
    logic [31:0] tsq;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata;
  logic [31:0] slaveId = 32'd0;
  logic [31:0] slaveTs = 32'd0;

  logic        mAddrA, mReadA, busyA, doneA, passA;
  logic [1:0]  failA;
  logic [31:0] idA, tsA;
  logic        mAddrB, mReadB, busyB, doneB, passB;
  logic [1:0]  failB;
  logic [31:0] idB, tsB;

  int vecCount = 0;
  int missCount = 0;
  exp_t expQ[$];
  logic [31:0] prevId = 32'd0;
  logic [31:0] prevTs = 32'd0;
  int doneCycle;
  int readRises;

  always #5 clock = ~clock;

  // Zero-latency slave: data follows the word the checker is addressing.
  assign m_readdata = mAddrA ? slaveTs : slaveId;

  sysid_check_ctrl #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b1),
    .TIMEOUT_CYC(TO), .MAX_RETRY(MR)
  ) dutA (
    .clock(clock), .reset_n(reset_n), .start(start),
    .m_address(mAddrA), .m_read(mReadA), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest), .busy(busyA), .done(doneA),
    .pass(passA), .fail_code(failA), .id_q(idA), .ts_q(tsA)
  );

  sysid_check_ctrl #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b0),
    .TIMEOUT_CYC(TO), .MAX_RETRY(MR)
  ) dutB (
    .clock(clock), .reset_n(reset_n), .start(start),
    .m_address(mAddrB), .m_read(mReadB), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest), .busy(busyB), .done(doneB),
    .pass(passB), .fail_code(failB), .id_q(idB), .ts_q(tsB)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vecCount++;
    if (act !== expv) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [1:0] verdict(input logic [31:0] id, input logic [31:0] ts, input bit chk);
    if (id != EXP_ID) return 2'd1;
    if (chk && (ts != EXP_TS)) return 2'd2;
    return 2'd0;
  endfunction

  // Per-cycle compare of both instances against the expected timeline.
  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("A.m_read", {31'd0, mReadA}, {31'd0, e.rd});
      checkOutput("B.m_read", {31'd0, mReadB}, {31'd0, e.rd});
      if (e.rd) begin
        checkOutput("A.m_address", {31'd0, mAddrA}, {31'd0, e.addr});
        checkOutput("B.m_address", {31'd0, mAddrB}, {31'd0, e.addr});
      end
      checkOutput("A.busy", {31'd0, busyA}, {31'd0, e.busy});
      checkOutput("B.busy", {31'd0, busyB}, {31'd0, e.busy});
      checkOutput("A.done", {31'd0, doneA}, {31'd0, e.done});
      checkOutput("B.done", {31'd0, doneB}, {31'd0, e.done});
      checkOutput("A.fail_code", {30'd0, failA}, {30'd0, (e.done ? e.codeA : 2'd0)});
      checkOutput("B.fail_code", {30'd0, failB}, {30'd0, (e.done ? e.codeB : 2'd0)});
      checkOutput("A.pass", {31'd0, passA}, {31'd0, (e.done && e.codeA == 2'd0)});
      checkOutput("B.pass", {31'd0, passB}, {31'd0, (e.done && e.codeB == 2'd0)});
      if (e.done) begin
        checkOutput("A.id_q", idA, e.idq);
        checkOutput("A.ts_q", tsA, e.tsq);
        checkOutput("B.id_q", idB, e.idq);
        checkOutput("B.ts_q", tsB, e.tsq);
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".m_read"}, {31'd0, mReadA}, 32'd0);
    checkOutput({tag, ".m_address"}, {31'd0, mAddrA}, 32'd0);
    checkOutput({tag, ".busy"}, {31'd0, busyA}, 32'd0);
    checkOutput({tag, ".done"}, {31'd0, doneA}, 32'd0);
    checkOutput({tag, ".pass"}, {31'd0, passA}, 32'd0);
    checkOutput({tag, ".fail_code"}, {30'd0, failA}, 32'd0);
    checkOutput({tag, ".id_q"}, idA, 32'd0);
    checkOutput({tag, ".ts_q"}, tsA, 32'd0);
    checkOutput({tag, ".B.busy"}, {31'd0, busyB}, 32'd0);
  endtask

  // One check run: build the expected timeline, launch, then step through it.
  task automatic applyStimulus(input logic [31:0] sid, input logic [31:0] sts, input int stallN,
                               input bit stuck, input bit viaReset, input int startAt);
    exp_t plan[$];
    exp_t e;
    logic [1:0] codeA, codeB;
    logic [31:0] newId, newTs;
    logic prevRd;
    slaveId = sid;
    slaveTs = sts;
    if (viaReset) begin
      prevId = 32'd0;
      prevTs = 32'd0;
    end
    e = '{rd: 1'b0, addr: 1'b0, busy: 1'b1, done: 1'b0, wr: 1'b0,
          codeA: 2'd0, codeB: 2'd0, idq: 32'd0, tsq: 32'd0};
    if (stuck) begin
      for (int a = 0; a <= MR; a++) begin
        for (int c = 0; c < TO; c++) begin
          e.rd = 1'b1; e.addr = 1'b0; e.wr = 1'b1; plan.push_back(e);
        end
        if (a < MR) begin
          e.rd = 1'b0; e.wr = 1'b1; plan.push_back(e);
        end
      end
      codeA = 2'd3; codeB = 2'd3; newId = prevId; newTs = prevTs;
    end else begin
      for (int w = 0; w < 2; w++) begin
        for (int c = 0; c <= stallN; c++) begin
          e.rd = 1'b1; e.addr = w[0]; e.wr = (c < stallN); plan.push_back(e);
        end
      end
      e.rd = 1'b0; e.wr = 1'b0; plan.push_back(e);
      codeA = verdict(sid, sts, 1'b1);
      codeB = verdict(sid, sts, 1'b0);
      newId = sid; newTs = sts;
    end
    for (int c = 0; c < 3; c++) begin
      e.rd = 1'b0; e.busy = 1'b0; e.done = 1'b1; e.wr = 1'b0;
      e.codeA = codeA; e.codeB = codeB; e.idq = newId; e.tsq = newTs;
      plan.push_back(e);
    end

    if (viaReset) begin
      reset_n = 1'b0;
      m_waitrequest = 1'b0;
      @(posedge clock); #1;
      checkAllZero("reset");
      @(negedge clock); #1;
      reset_n = 1'b1;
    end else begin
      @(posedge clock); #1;
      start = 1'b1;
      @(negedge clock); #1;
    end
    foreach (plan[i]) expQ.push_back(plan[i]);

    doneCycle = 0;
    readRises = 0;
    prevRd = 1'b0;
    foreach (plan[i]) begin
      @(posedge clock); #1;
      start = ((i + 1) == startAt);
      m_waitrequest = plan[i].wr;
      if (doneA && doneCycle == 0) doneCycle = i + 1;
      if (mReadA && !prevRd && !mAddrA) readRises++;
      prevRd = mReadA;
    end
    @(negedge clock); #1;
    start = 1'b0;
    prevId = newId;
    prevTs = newTs;
  endtask

  initial begin
    // Boot auto-run, all matching, no stalls.
    applyStimulus(32'h0, 32'h5AA5_0003, 0, 1'b0, 1'b1, 0);
    checkOutput("boot.done_cycle", doneCycle, 32'd4);
    checkOutput("boot.pass", {31'd0, passA}, 32'd1);
    checkOutput("boot.fail_code", {30'd0, failA}, 32'd0);
    checkOutput("boot.ts_q", tsA, 32'h5AA5_0003);

    applyStimulus(32'h1, 32'h5AA5_0003, 0, 1'b0, 1'b0, 0);
    checkOutput("idbad.fail_code", {30'd0, failA}, 32'd1);
    checkOutput("idbad.pass", {31'd0, passA}, 32'd0);

    applyStimulus(32'h1, 32'h0000_0000, 0, 1'b0, 1'b0, 0);
    checkOutput("bothbad.fail_code", {30'd0, failA}, 32'd1);

    applyStimulus(32'h0, 32'h0000_0000, 0, 1'b0, 1'b0, 0);
    checkOutput("tsbad.A.fail_code", {30'd0, failA}, 32'd2);
    checkOutput("tsbad.B.pass", {31'd0, passB}, 32'd1);

    applyStimulus(32'h0, 32'h5AA5_0003, 3, 1'b0, 1'b0, 0);
    checkOutput("stall.done_cycle", doneCycle, 32'd10);
    checkOutput("stall.pass", {31'd0, passA}, 32'd1);

    applyStimulus(32'h0, 32'h5AA5_0003, 0, 1'b1, 1'b0, 0);
    checkOutput("timeout.attempts", readRises, 32'd2);
    checkOutput("timeout.fail_code", {30'd0, failA}, 32'd3);
    checkOutput("timeout.done", {31'd0, doneA}, 32'd1);

    // Start pulse while reading the timestamp must be ignored.
    applyStimulus(32'h0, 32'h5AA5_0003, 0, 1'b0, 1'b0, 2);
    checkOutput("startbusy.pass", {31'd0, passA}, 32'd1);

    // Reset asserted in RD_TS, then the auto-run repeats.
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    m_waitrequest = 1'b0;
    @(posedge clock); #1;
    checkOutput("midrst.pre.m_read", {31'd0, mReadA}, 32'd1);
    checkOutput("midrst.pre.m_address", {31'd0, mAddrA}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkAllZero("midrst");
    applyStimulus(32'h0, 32'h5AA5_0003, 0, 1'b0, 1'b1, 0);
    checkOutput("midrst.rerun.pass", {31'd0, passA}, 32'd1);
    checkOutput("midrst.rerun.done_cycle", doneCycle, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
